// File: rtl/sha_pad_ctrl.sv
// sha_pad_ctrl: SHA-256 single-block front end.
// Packs, pads and length-tags a short message, runs the core, returns the digest.
module sha_pad_ctrl (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    input  logic         in_empty,
    output logic         core_start,
    output logic [511:0] core_msg,
    input  logic         core_valid,
    input  logic [255:0] core_hash,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE, LOAD, PAD, START, WAIT, OUT, DRAIN, SKIP
    } state_t;

    state_t            state;
    logic [0:15][31:0] msg;
    logic [3:0]        widx;
    logic [3:0]        pidx;
    logic [1:0]        pbyte;
    logic [8:0]        len;

    logic              accept;
    logic [2:0]        nb;
    logic [6:0]        tot;
    logic [31:0]       wdata;

    // Keep the top n bytes of a word.
    function automatic logic [31:0] bmask(input logic [2:0] n);
        logic [31:0] m;
        unique case (n)
            3'd0:    m = 32'h0000_0000;
            3'd1:    m = 32'hFF00_0000;
            3'd2:    m = 32'hFFFF_0000;
            3'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    assign core_msg = msg;

    // Word acceptance, valid byte count and running message length.
    always_comb begin
        in_ready = 1'b0;
        if (!clr && !core_valid)
            in_ready = (state == IDLE) || (state == LOAD) ||
                       (state == SKIP);
        accept = in_valid & in_ready;
        nb = 3'd4;
        if (in_last && in_empty)
            nb = 3'd0;
        else if (in_last && in_bytes != 2'd0)
            nb = {1'b0, in_bytes};
        tot   = {1'b0, widx, 2'b00} + {4'b0, nb};
        wdata = in_data & bmask(nb);
    end

    // Controller FSM with block storage, padding and digest capture.
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= IDLE;
            msg          <= '0;
            widx         <= '0;
            pidx         <= '0;
            pbyte        <= '0;
            len          <= '0;
            core_start   <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            core_start <= 1'b0;
            err        <= 1'b0;
            unique case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (widx < 4'd14)
                            msg[widx] <= wdata;
                        widx <= widx + 4'd1;
                        if (in_last) begin
                            if (tot > 7'd55) begin
                                err   <= 1'b1;
                                widx  <= '0;
                                state <= IDLE;
                            end else begin
                                len   <= {tot[5:0], 3'b000};
                                pidx  <= widx + 4'(nb == 3'd4);
                                pbyte <= nb[1:0];
                                state <= PAD;
                            end
                        end else if (widx == 4'd14) begin
                            state <= SKIP;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                SKIP: begin
                    if (accept && in_last) begin
                        err   <= 1'b1;
                        widx  <= '0;
                        state <= IDLE;
                    end
                end
                PAD: begin
                    for (int i = 0; i < 14; i++) begin
                        if (4'(i) == pidx)
                            msg[i] <= (msg[i] & bmask({1'b0, pbyte})) |
                                      (32'h8000_0000 >> {pbyte, 3'b000});
                        else if (4'(i) > pidx)
                            msg[i] <= '0;
                    end
                    msg[14]    <= '0;
                    msg[15]    <= {23'b0, len};
                    core_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_valid) begin
                        digest       <= core_hash;
                        digest_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!core_valid) begin
                        widx  <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_pad_ctrl.sv
// tb_sha_pad_ctrl: random and directed messages against a byte-level model.
// A behavioural SHA-256 core answers core_start; a scoreboard checks outputs.
module tb_sha_pad_ctrl;

    logic         clk = 1'b0;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         in_empty;
    logic         core_start;
    logic [511:0] core_msg;
    logic         core_valid;
    logic [255:0] core_hash;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         err;

    sha_pad_ctrl dut (
        .clk(clk), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .in_bytes(in_bytes), .in_empty(in_empty),
        .core_start(core_start), .core_msg(core_msg),
        .core_valid(core_valid), .core_hash(core_hash),
        .digest(digest), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] ABC_H =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_H =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256(input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = IV[i];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i] + IV[i];
        return r;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or bound expired", name);
    endtask

    // Core model: valid for two cycles, 66 cycles after the start cycle.
    int           ccnt = 0;
    logic [255:0] chash = '0;
    always @(posedge clk) begin
        if (clr) ccnt <= 0;
        else if (core_start) begin
            ccnt  <= 1;
            chash <= sha256(core_msg);
        end else if (ccnt == 67) ccnt <= 0;
        else if (ccnt != 0) ccnt <= ccnt + 1;
    end
    assign core_valid = (ccnt >= 66);
    assign core_hash  = chash;

    bit rdy_low = 1'b0;
    always @(posedge clk) begin
        #1 digest_ready = rdy_low ? 1'b0 : ($urandom % 4 != 0);
    end

    typedef struct {
        bit           is_err;
        logic [511:0] blk;
    } ev_t;

    ev_t          evq [$];
    logic [255:0] dq [$];
    int           last_cyc = 0;
    int           start_cyc = 0;
    bit           dv_q = 1'b0;

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin : mon
        ev_t e;
        if (clr) dv_q = 1'b0;
        else begin
            if (core_start) begin
                if (evq.size() == 0) fail("start_unexpected");
                else begin
                    e = evq.pop_front();
                    chk("start_kind", 512'(e.is_err), 512'(0));
                    chk("core_msg", core_msg, e.blk);
                    chk("start_lat", 512'(cyc - last_cyc), 512'(2));
                end
                start_cyc = cyc;
            end
            if (err) begin
                if (evq.size() == 0) fail("err_unexpected");
                else begin
                    e = evq.pop_front();
                    chk("err_kind", 512'(e.is_err), 512'(1));
                    chk("err_lat", 512'(cyc - last_cyc), 512'(1));
                end
            end
            if (digest_valid && !dv_q)
                chk("digest_lat", 512'(cyc - start_cyc), 512'(67));
            if (digest_valid && digest_ready) begin
                if (dq.size() == 0) fail("digest_unexpected");
                else chk("digest", 512'(digest), 512'(dq.pop_front()));
            end
            dv_q = digest_valid;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l,
                             input logic [1:0] b, input logic e);
        int n = 0;
        while ($urandom % 4 == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        in_empty = e;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("in_ready_timeout");
        else if (l) last_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m [$], input bit use_known,
                            input logic [255:0] known);
        int           len = m.size();
        int           nw;
        int           k;
        logic [7:0]   bb [64];
        logic [511:0] blk;
        logic [31:0]  wd;
        ev_t          e;
        if (len > 55) begin
            e.is_err = 1'b1;
            e.blk    = '0;
            evq.push_back(e);
        end else begin
            for (int i = 0; i < 64; i++) bb[i] = 8'h00;
            for (int i = 0; i < len; i++) bb[i] = m[i];
            bb[len] = 8'h80;
            bb[62]  = 8'((len * 8) >> 8);
            bb[63]  = 8'(len * 8);
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = bb[i];
            e.is_err = 1'b0;
            e.blk    = blk;
            evq.push_back(e);
            dq.push_back(use_known ? known : sha256(blk));
        end
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++) begin
                k = 4 * i + j;
                wd[31-8*j -: 8] = (k < len) ? m[k] : 8'($urandom);
            end
            send_word(wd, i == nw - 1, 2'(len % 4), len == 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((evq.size() != 0 || dq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 512'(evq.size() + dq.size()), 512'(0));
    endtask

    task automatic rand_msg(output logic [7:0] m [$], input int len);
        m.delete();
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_start", 512'(core_start), 512'(0));
        chk("rst_msg", core_msg, 512'(0));
        chk("rst_digest", 512'(digest), 512'(0));
        chk("rst_dvalid", 512'(digest_valid), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
    endtask

    logic [7:0]   m [$];
    logic [255:0] d0;
    int           n;

    initial begin
        clr          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        in_bytes     = '0;
        in_empty     = 1'b0;
        digest_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset();
        clr = 1'b0;
        @(negedge clk);

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, ABC_H);
        m = {};
        send_msg(m, 1'b1, EMPTY_H);
        rand_msg(m, 55); send_msg(m, 1'b0, '0);
        rand_msg(m, 56); send_msg(m, 1'b0, '0);
        rand_msg(m, 80); send_msg(m, 1'b0, '0);
        rand_msg(m, 52); send_msg(m, 1'b0, '0);
        rand_msg(m, 57); send_msg(m, 1'b0, '0);

        // Digest held while the consumer stalls.
        wait_idle();
        rdy_low = 1'b1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, ABC_H);
        n = 0;
        while (!digest_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!digest_valid) fail("hold_dvalid_timeout");
        d0 = digest;
        repeat (10) begin
            @(negedge clk);
            chk("hold_dvalid", 512'(digest_valid), 512'(1));
            chk("hold_digest", 512'(digest), 512'(d0));
            chk("hold_in_ready", 512'(in_ready), 512'(0));
        end
        rdy_low = 1'b0;

        // Reset while waiting for the core.
        wait_idle();
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, ABC_H);
        n = 0;
        while (!core_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) fail("reset_start_timeout");
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk_reset();
        clr = 1'b0;
        dq.delete();
        @(negedge clk);
        send_msg(m, 1'b1, ABC_H);

        for (int t = 0; t < 25; t++) begin
            rand_msg(m, int'($urandom_range(0, 60)));
            send_msg(m, 1'b0, '0);
        end

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_pad_ctrl.md
# sha_pad_ctrl

Front-end controller for the single-block SHA-256 core. It accepts a byte-oriented message as a stream of 32-bit big-endian words, applies SHA-256 padding and the length field, and drives the core's `start`/`message` inputs. It then waits for the core's `valid`, captures `hashvalue`, and presents the digest on a valid/ready output. It is the initiator and consumer of the core's start/valid protocol, and is limited to messages of 0–55 bytes (one 512-bit block, fixed IV).

## Interface
- No parameters (block size 512, word 32, max message 55 bytes are fixed).
- `clk`  in  1  — single clock, shared with the core.
- `clr`  in  1  — reset, synchronous, active-high; system derives the core's active-low `clr` from the same source.
- `in_valid`  in  1  — input word valid.
- `in_ready`  out  1  — controller can accept a word.
- `in_data`  in  32  — message word; first byte in [31:24].
- `in_last`  in  1  — final word of the message.
- `in_bytes`  in  2  — valid bytes in final word, MSB-aligned; 0 encodes 4. Ignored unless `in_last`.
- `in_empty`  in  1  — with `in_last`, the message is zero length and `in_data` is ignored.
- `core_start`  out  1  — one-cycle start pulse to the core.
- `core_msg`  out  512  — padded block; w0 at [511:480].
- `core_valid`  in  1  — core `valid`.
- `core_hash`  in  256  — core `hashvalue`.
- `digest`  out  256  — captured hash.
- `digest_valid`  out  1  — digest available.
- `digest_ready`  in  1  — consumer accepts the digest.
- `err`  out  1  — one-cycle pulse: message exceeded 55 bytes.

## Operation
- States: IDLE, LOAD, PAD, START, WAIT, OUT, DRAIN, SKIP.
- **Word acceptance**
  - `in_ready` = 1 in IDLE and LOAD, and in SKIP (which discards words).
  - `in_ready` = 0 everywhere else, and also whenever `core_valid` = 1.
  - A word is accepted when `in_valid & in_ready`.
  - IDLE→LOAD on the first accepted word, unless it is also last (then →PAD).
- **Storage**
  - Word index counter `widx` (4 bits) starts at 0 in IDLE.
  - Each accepted word is written to `core_msg` word `widx`, then `widx` increments.
  - Bytes past `in_bytes` in the last word are forced to 0.
- **Bit length**
  - Bit length L = 8 × (4 × (words − 1) + nb), where nb = `in_bytes` (0→4).
  - L = 0 when `in_empty`.
- **Padding (PAD, one cycle)**
  - 0x80 goes in the byte immediately after the last data byte.
  - If nb = 4, the 0x80 goes in [31:24] of word `widx`.
  - If `in_empty`, w0 = 0x80000000.
  - All remaining words up to w13 are zeroed.
  - w14 = 0; w15 = L (at most 440 = 0x1B8).
- **Overflow**
  - Overflow occurs when a 15th word is accepted, or when the 14th word is last with nb = 4 (56 bytes).
  - Non-last overflow → SKIP, which accepts and drops words until `in_last`.
  - In both cases `err` pulses in the cycle after the last word is accepted, the state returns to IDLE, and no `core_start` is issued.
- **Core handshake**
  - PAD→START.
  - START drives `core_start` = 1 for exactly one cycle, then →WAIT.
  - `core_msg` is held stable from PAD until the next message's first accepted word.
- **Capture**
  - In WAIT, the first cycle with `core_valid` = 1 loads `digest` ← `core_hash`, then →OUT.
- **Output**
  - OUT holds `digest_valid` = 1 until `digest_ready` = 1.
  - On that cycle `digest_valid` drops, then →DRAIN.
  - `digest` holds its value until the next capture.
- **Drain**
  - DRAIN→IDLE once `core_valid` = 0. This guarantees the core counter is back at 0 before the next start.
- **Reset**
  - `clr` = 1 in any state forces IDLE.
  - Reset values: `in_ready` = 0 during reset, `core_start` = 0, `core_msg` = 0, `digest` = 0, `digest_valid` = 0, `err` = 0, `widx` = 0.
  - A mid-message or mid-hash reset discards everything; the core is reset concurrently via the shared source.

## Timing
- Last word accepted in cycle T → PAD at T+1 → `core_start` at T+2.
- With the current core, `core_valid` rises 66 cycles after the `core_start` cycle.
- `digest_valid` rises 1 cycle after `core_valid` rises (67 cycles after `core_start`).
- `core_valid` stays high for 2 cycles; the capture must use the first.
- `digest_valid` with `digest_ready` already high: one-cycle pulse, digest accepted.
- Back-to-back messages: a new first word can be accepted the cycle after DRAIN exits.
- Maximum throughput is one message per ~71 + N cycles for an N-word message.
- `in_valid` deasserted mid-message: LOAD waits indefinitely; there is no timeout.

## Test plan
- "abc" (`in_data` = 0x61626300, `in_last`, `in_bytes` = 3) → `core_msg` w0 = 0x61626380, w1–w14 = 0, w15 = 0x18; `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (`in_empty`, `in_last`) → w0 = 0x80000000, w15 = 0; `digest` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 55 bytes (13 full words + last with `in_bytes` = 3) → w13 byte 3 = 0x80, w15 = 0x1B8, `core_start` issued; 56 bytes → `err` pulse, no `core_start`, back to IDLE.
- 20-word message → words 15–20 accepted and dropped, `err` pulse after the 20th word, `core_start` never asserted.
- Hold `digest_ready` = 0 for 10 cycles → `digest_valid` and `digest` stable; next message not accepted until release and `core_valid` = 0.
- Assert `clr` in WAIT → all outputs 0 next cycle; a subsequent "abc" run gives the correct digest.
